mag_comp_seq: RTL and testbench

//  Parametrised, sequential, MSB-first N-bit magnitude comparator. Successor to the fixed 2-bit comparator.

---
 rtl/comp_pkg.sv | 28 ++
 rtl/comp_chunk.sv | 18 +
 rtl/mag_comp_seq.sv | 125 ++++++++++++
 tb/tb_mag_comp_seq.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_pkg.sv
// Shared encodings and helpers for the sequential magnitude comparator.
package comp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Result bits are laid out as {lt, eq, gt} so they drive the ports directly.
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_LT   = 3'b100;
    localparam logic [2:0] RES_EQ   = 3'b010;
    localparam logic [2:0] RES_GT   = 3'b001;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational CHUNK-bit unsigned compare cell; generalisation of the 2-bit comparator.
module comp_chunk
    import comp_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (x < y);
    assign eq = (x == y);
    assign gt = (x > y);

endmodule

// File: rtl/mag_comp_seq.sv
// Sequential MSB-first magnitude comparator: CHUNK bits per cycle, early exit on the
// first differing chunk, unsigned or two's-complement, valid/ready on both sides.
module mag_comp_seq
    import comp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CHUNK     = 2,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = clog2(NCHUNK) + 1;

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("mag_comp_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sa_d;
    logic [WIDTH-1:0] sb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       res_q;
    logic             rdy_q;
    logic             vld_q;
    logic             c_lt;
    logic             c_eq;
    logic             c_gt;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        sa_d = a;
        sb_d = b;
        if (SIGNED_EN && signed_mode) begin
            sa_d[WIDTH-1] = ~a[WIDTH-1];
            sb_d[WIDTH-1] = ~b[WIDTH-1];
        end
    end

    comp_chunk #(
        .CHUNK(CHUNK)
    ) u_cell (
        .x  (sa_q[WIDTH-1 -: CHUNK]),
        .y  (sb_q[WIDTH-1 -: CHUNK]),
        .lt (c_lt),
        .eq (c_eq),
        .gt (c_gt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            res_q   <= RES_NONE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        sa_q    <= sa_d;
                        sb_q    <= sb_d;
                        cnt_q   <= CNT_W'(NCHUNK - 1);
                        rdy_q   <= 1'b0;
                        state_q <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (c_lt) begin
                        res_q   <= RES_LT;
                        vld_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (c_gt) begin
                        res_q   <= RES_GT;
                        vld_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (c_eq && cnt_q == '0) begin
                        res_q   <= RES_EQ;
                        vld_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        sa_q  <= sa_q << CHUNK;
                        sb_q  <= sb_q << CHUNK;
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        vld_q   <= 1'b0;
                        res_q   <= RES_NONE;
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rdy_q   <= 1'b1;
                    vld_q   <= 1'b0;
                    res_q   <= RES_NONE;
                end
            endcase
        end
    end

    assign start_ready    = rdy_q;
    assign res_valid      = vld_q;
    assign {lt, eq, gt}   = res_q;

endmodule

// File: tb/tb_mag_comp_seq.sv
// Scoreboard bench for mag_comp_seq: directed scenarios plus random vectors.
module tb_mag_comp_seq;

    parameter int CHUNK = 2;
    localparam int W   = 8;
    localparam int NCH = W / CHUNK;

    typedef struct {
        logic [2:0] res;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         signed_mode = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic         lt, eq, gt;

    logic         u_start_valid = 1'b0;
    logic         u_start_ready;
    logic [W-1:0] u_a = '0;
    logic [W-1:0] u_b = '0;
    logic         u_mode = 1'b0;
    logic         u_res_valid;
    logic         u_res_ready = 1'b1;
    logic         u_lt, u_eq, u_gt;

    always #5 clk = ~clk;

    mag_comp_seq #(.WIDTH(W), .CHUNK(CHUNK), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .res_valid(res_valid),
        .res_ready(res_ready), .lt(lt), .eq(eq), .gt(gt)
    );

    mag_comp_seq #(.WIDTH(W), .CHUNK(CHUNK), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start_valid(u_start_valid), .start_ready(u_start_ready),
        .a(u_a), .b(u_b), .signed_mode(u_mode), .res_valid(u_res_valid),
        .res_ready(u_res_ready), .lt(u_lt), .eq(u_eq), .gt(u_gt)
    );

    function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        if (m) begin
            if ($signed(x) < $signed(y)) return 3'b100;
            if ($signed(x) > $signed(y)) return 3'b001;
            return 3'b010;
        end
        if (x < y) return 3'b100;
        if (x > y) return 3'b001;
        return 3'b010;
    endfunction

    // Cycles from the accept edge (counted as 1) until res_valid is seen.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        logic [W-1:0] fx;
        logic [W-1:0] fy;
        fx = x;
        fy = y;
        if (m) begin
            fx[W-1] = ~fx[W-1];
            fy[W-1] = ~fy[W-1];
        end
        for (int i = 0; i < NCH; i++) begin
            if (fx[W-1-i*CHUNK -: CHUNK] != fy[W-1-i*CHUNK -: CHUNK]) return i + 2;
        end
        return NCH + 1;
    endfunction

    // Called and returns at a negedge. hold>0 keeps res_ready low that many cycles.
    task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm,
                           input bit keep_valid, input int hold, input string nm);
        exp_t       e;
        exp_t       got;
        int         lat;
        int         waits;
        logic [2:0] held;
        a = ta; b = tb_v; signed_mode = tm; start_valid = 1'b1; res_ready = (hold == 0);
        waits = 0;
        while (start_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        total++;
        if (start_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s accept: start_ready=%b required 1", nm, start_ready);
            start_valid = 1'b0;
            return;
        end
        if (keep_valid) begin
            total++;
            if (waits != 0) begin
                bad++;
                $display("FAIL %s b2b_accept: waited %0d cycles required 0", nm, waits);
            end
        end
        e.res = ref_res(ta, tb_v, tm);
        e.lat = ref_lat(ta, tb_v, tm);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (!keep_valid) begin
            start_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            signed_mode = 1'($urandom);
        end
        lat = 1;
        @(negedge clk);
        while (res_valid !== 1'b1 && lat < NCH + 4) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total++;
        if (res_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout: res_valid=%b after %0d cycles required 1", nm, res_valid, lat);
            void'(sbq.pop_front());
            return;
        end
        got = sbq.pop_front();
        total++;
        if ({lt, eq, gt} !== got.res) begin
            bad++;
            $display("FAIL %s result: a=%h b=%h m=%b lt/eq/gt=%b required %b", nm, ta, tb_v, tm, {lt, eq, gt}, got.res);
        end
        total++;
        if (lat != got.lat) begin
            bad++;
            $display("FAIL %s latency: got %0d required %0d", nm, lat, got.lat);
        end
        total++;
        if (lat > NCH + 1 || lat < 2) begin
            bad++;
            $display("FAIL %s latency_bound: got %0d required 2..%0d", nm, lat, NCH + 1);
        end
        total++;
        if (!$onehot({lt, eq, gt})) begin
            bad++;
            $display("FAIL %s onehot: lt/eq/gt=%b required one-hot", nm, {lt, eq, gt});
        end
        if (hold > 0) begin
            held = {lt, eq, gt};
            a = ~ta;
            start_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                total++;
                if ({res_valid, start_ready, lt, eq, gt} !== {2'b10, held}) begin
                    bad++;
                    $display("FAIL %s hold: vld/rdy/lt/eq/gt=%b required %b", nm,
                             {res_valid, start_ready, lt, eq, gt}, {2'b10, held});
                end
            end
            res_ready = 1'b1;
        end
        @(negedge clk);
        total++;
        if ({res_valid, start_ready, lt, eq, gt} !== 5'b01000) begin
            bad++;
            $display("FAIL %s release: vld/rdy/lt/eq/gt=%b required 01000", nm,
                     {res_valid, start_ready, lt, eq, gt});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({start_ready, res_valid, lt, eq, gt} !== 5'b10000) begin
            bad++;
            $display("FAIL reset: rdy/vld/lt/eq/gt=%b required 10000", {start_ready, res_valid, lt, eq, gt});
        end
        total++;
        if ({u_start_ready, u_res_valid, u_lt, u_eq, u_gt} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_u: rdy/vld/lt/eq/gt=%b required 10000",
                     {u_start_ready, u_res_valid, u_lt, u_eq, u_gt});
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned_gt();
        run_one(8'hA5, 8'h3C, 1'b0, 1'b0, 0, "unsigned_gt");
    endtask

    task automatic test_equal();
        run_one(8'h5A, 8'h5A, 1'b0, 1'b0, 0, "equal");
    endtask

    task automatic test_signed();
        int waits;
        run_one(8'h80, 8'h7F, 1'b1, 1'b0, 0, "signed_lt");
        run_one(8'h80, 8'h7F, 1'b0, 1'b0, 0, "unsigned_gt_80");
        for (int m = 0; m < 2; m++) begin
            u_a = 8'h80; u_b = 8'h7F; u_mode = 1'(m); u_start_valid = 1'b1; u_res_ready = 1'b1;
            @(posedge clk);
            #1;
            u_start_valid = 1'b0;
            waits = 0;
            @(negedge clk);
            while (u_res_valid !== 1'b1 && waits < NCH + 4) begin
                @(negedge clk);
                waits++;
            end
            total++;
            if ({u_res_valid, u_lt, u_eq, u_gt} !== 4'b1001) begin
                bad++;
                $display("FAIL signed_disabled m=%0d: vld/lt/eq/gt=%b required 1001", m,
                         {u_res_valid, u_lt, u_eq, u_gt});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        run_one(8'h12, 8'h34, 1'b0, 1'b0, 3, "hold");
        run_one(8'hED, 8'h34, 1'b0, 1'b0, 0, "hold_next");
    endtask

    task automatic test_reset_mid();
        bit stale;
        a = 8'h01; b = 8'h02; signed_mode = 1'b0; start_valid = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({start_ready, res_valid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid busy: rdy/vld=%b required 00", {start_ready, res_valid});
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({start_ready, res_valid, lt, eq, gt} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_mid: rdy/vld/lt/eq/gt=%b required 10000", {start_ready, res_valid, lt, eq, gt});
        end
        stale = 1'b0;
        repeat (NCH + 3) begin
            @(negedge clk);
            if (res_valid !== 1'b0) stale = 1'b1;
        end
        total++;
        if (stale) begin
            bad++;
            $display("FAIL reset_mid stale: res_valid seen 1 required 0");
        end
    endtask

    task automatic test_back_to_back();
        run_one(8'h10, 8'h20, 1'b0, 1'b1, 0, "b2b_lt");
        run_one(8'hFF, 8'hFF, 1'b0, 1'b1, 0, "b2b_eq");
        start_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        for (int i = 0; i < 10000; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
            if ($urandom_range(0, 3) == 0) rb[W-1 -: CHUNK] = ra[W-1 -: CHUNK];
            run_one(ra, rb, 1'($urandom), 1'b0, 0, "random");
        end
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_gt();
        test_equal();
        test_signed();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
